// File: rtl/lbp_scan_ctrl.sv
// Raster-scan sequencer for the LBP pipeline: fetches each interior pixel's 3x3 window,
// streams it to the LBP core, and writes the core's code (or 0 for border pixels) to the LBP RAM.
module lbp_scan_ctrl #(
   parameter int IMG_W     = 64,
   parameter int IMG_H     = 64,
   parameter int ADDRWIDTH = 12,
   parameter int DATAWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   output logic [ADDRWIDTH-1:0] gray_addr,
   output logic                 gray_OE,
   input  logic [DATAWIDTH-1:0] gray_data,
   output logic [DATAWIDTH-1:0] win_data,
   output logic [3:0]           win_idx,
   output logic                 win_valid,
   output logic                 win_last,
   input  logic [DATAWIDTH-1:0] core_result,
   input  logic                 core_valid,
   output logic [ADDRWIDTH-1:0] lbp_addr,
   output logic                 lbp_WEN,
   output logic [DATAWIDTH-1:0] lbp_data,
   output logic                 busy,
   output logic                 finish
);

   localparam int COLW = $clog2(IMG_W);
   localparam int ROWW = ADDRWIDTH - COLW;
   localparam logic [ADDRWIDTH-1:0] LAST_PIX = ADDRWIDTH'(IMG_W * IMG_H - 1);
   localparam logic [ADDRWIDTH-1:0] W_OFF    = ADDRWIDTH'(IMG_W);
   localparam logic [ADDRWIDTH-1:0] ONE      = ADDRWIDTH'(1);
   localparam logic [3:0]           K_LAST   = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_FETCH,
      S_WAIT_CORE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ADDRWIDTH-1:0]   r_pix;
   logic [ADDRWIDTH-1:0]   r_gray_addr;
   logic [ADDRWIDTH-1:0]   r_lbp_addr;
   logic [ADDRWIDTH-1:0]   w_fetch_addr;
   logic [3:0]             r_k;
   logic [3:0]             r_win_idx;
   logic                   r_win_valid;
   logic                   r_win_last;
   logic [DATAWIDTH-1:0]   r_result;
   logic [COLW-1:0]        w_col;
   logic [ROWW-1:0]        w_row;
   logic                   w_border;
   logic                   w_start;
   logic                   w_last_pix;
   logic                   w_fetch;
   logic                   w_write;

   assign w_col      = r_pix[COLW-1:0];
   assign w_row      = r_pix[ADDRWIDTH-1:COLW];
   assign w_border   = (w_col == '0) || (w_col == COLW'(IMG_W - 1)) ||
                       (w_row == '0) || (w_row == ROWW'(IMG_H - 1));
   assign w_start    = ((r_state == S_IDLE) || (r_state == S_DONE)) && enable;
   assign w_last_pix = (r_pix == LAST_PIX);
   assign w_fetch    = (r_state == S_FETCH);
   assign w_write    = (r_state == S_WRITE);

   // Window order: center first, then the 8 neighbours row by row; wraps are harmless
   // because only interior pixels are ever fetched.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_fetch_addr = r_pix;
      case (r_k)
         4'd1:    w_fetch_addr = r_pix - W_OFF - ONE;
         4'd2:    w_fetch_addr = r_pix - W_OFF;
         4'd3:    w_fetch_addr = r_pix - W_OFF + ONE;
         4'd4:    w_fetch_addr = r_pix - ONE;
         4'd5:    w_fetch_addr = r_pix + ONE;
         4'd6:    w_fetch_addr = r_pix + W_OFF - ONE;
         4'd7:    w_fetch_addr = r_pix + W_OFF;
         4'd8:    w_fetch_addr = r_pix + W_OFF + ONE;
         default: w_fetch_addr = r_pix;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (enable) w_state_nxt = S_SELECT;
         S_SELECT:       w_state_nxt = w_border ? S_WRITE : S_FETCH;
         S_FETCH:        if (r_k == K_LAST) w_state_nxt = S_WAIT_CORE;
         S_WAIT_CORE:    if (core_valid) w_state_nxt = S_WRITE;
         S_WRITE:        w_state_nxt = w_last_pix ? S_DONE : S_SELECT;
         default:        w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_pix       <= '0;
         r_k         <= '0;
         r_gray_addr <= '0;
         r_lbp_addr  <= '0;
         r_result    <= '0;
         r_win_valid <= 1'b0;
         r_win_idx   <= '0;
         r_win_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_start)
            r_pix <= '0;
         else if (w_write && !w_last_pix)
            r_pix <= r_pix + ONE;

         if (r_state == S_SELECT)
            r_k <= '0;
         else if (w_fetch)
            r_k <= r_k + 4'd1;

         if (w_fetch)
            r_gray_addr <= w_fetch_addr;
         if (w_write)
            r_lbp_addr <= r_pix;

         // A core_valid seen in any other state is stale or spurious and must not overwrite.
         if ((r_state == S_WAIT_CORE) && core_valid)
            r_result <= core_result;

         r_win_valid <= w_fetch;
         r_win_idx   <= w_fetch ? r_k : '0;
         r_win_last  <= w_fetch && (r_k == K_LAST);
      end
   end

   assign gray_OE   = w_fetch;
   assign gray_addr = w_fetch ? w_fetch_addr : r_gray_addr;
   assign lbp_WEN   = w_write;
   assign lbp_addr  = w_write ? r_pix : r_lbp_addr;
   assign lbp_data  = (w_write && !w_border) ? r_result : '0;
   assign win_valid = r_win_valid;
   assign win_idx   = r_win_idx;
   assign win_last  = r_win_last;
   assign win_data  = r_win_valid ? gray_data : '0;
   assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign finish    = (r_state == S_DONE);

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Scoreboard bench for lbp_scan_ctrl: RAM and LBP-core models, expected fetch/window/write
// streams queued at stimulus time and popped as the controller produces them.
`timescale 1ns/1ps
module tb_lbp_scan_ctrl;

   localparam int W      = 64;
   localparam int H      = 64;
   localparam int NPIX   = W * H;
   localparam int PERIOD = 10;

   typedef struct packed {
      logic [3:0] idx;
      logic [7:0] data;
      logic       last;
   } win_t;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [11:0] gray_addr;
   logic        gray_OE;
   logic [7:0]  gray_data = 8'h00;
   logic [7:0]  win_data;
   logic [3:0]  win_idx;
   logic        win_valid;
   logic        win_last;
   logic [7:0]  core_result = 8'h00;
   logic        core_valid = 1'b0;
   logic [11:0] lbp_addr;
   logic        lbp_WEN;
   logic [7:0]  lbp_data;
   logic        busy;
   logic        finish;

   lbp_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDRWIDTH(12), .DATAWIDTH(8)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .gray_addr(gray_addr), .gray_OE(gray_OE), .gray_data(gray_data),
      .win_data(win_data), .win_idx(win_idx), .win_valid(win_valid), .win_last(win_last),
      .core_result(core_result), .core_valid(core_valid),
      .lbp_addr(lbp_addr), .lbp_WEN(lbp_WEN), .lbp_data(lbp_data),
      .busy(busy), .finish(finish)
   );

   always #(PERIOD / 2) clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  gray_mem [NPIX];
   logic [7:0]  lbp_mem  [NPIX];
   logic [11:0] ga_q [$];
   win_t        win_q [$];
   wr_t         wr_q [$];
   int          core_d    = 0;
   logic [7:0]  core_resp = 8'h00;
   bit          spur_req  = 1'b0;
   bit          mon_en    = 1'b1;
   time         t_start;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit is_border(input int p);
      return (p / W == 0) || (p / W == H - 1) || (p % W == 0) || (p % W == W - 1);
   endfunction

   task automatic push_pixel(input int p, input logic [7:0] resp);
      int offs [9];
      offs = '{0, -W - 1, -W, -W + 1, -1, 1, W - 1, W, W + 1};
      if (is_border(p)) begin
         wr_q.push_back('{addr: 12'(p), data: 8'h00});
      end else begin
         for (int k = 0; k < 9; k++) begin
            logic [11:0] a;
            a = 12'(p + offs[k]);
            ga_q.push_back(a);
            win_q.push_back('{idx: 4'(k), data: gray_mem[a], last: (k == 8)});
         end
         wr_q.push_back('{addr: 12'(p), data: resp});
      end
   endtask

   task automatic start_scan();
      @(negedge clk);
      enable = 1'b1;
      @(posedge clk);
      t_start = $time;
      @(negedge clk);
      enable = 1'b0;
   endtask

   // Gray RAM: registered read, data valid the cycle after the strobe.
   always @(posedge clk) if (gray_OE) gray_data <= gray_mem[gray_addr];

   // LBP core model: answers core_d+1 cycles after win_last; optionally fires one stray pulse in FETCH.
   initial begin
      forever begin
         @(negedge clk);
         if (win_last) begin
            repeat (core_d + 1) @(negedge clk);
            core_result = core_resp;
            core_valid  = 1'b1;
            @(negedge clk);
            core_valid  = 1'b0;
         end else if (spur_req && gray_OE) begin
            core_result = 8'h3C;
            core_valid  = 1'b1;
            @(negedge clk);
            core_valid  = 1'b0;
            spur_req    = 1'b0;
         end
      end
   end

   // Monitor: pops scoreboards and checks strobe timing on the falling edge.
   bit prev_oe  = 1'b0;
   int oe_run   = 0;
   int wv_run   = 0;
   bit in_gap   = 1'b0;
   int gap      = 0;

   always @(negedge clk) begin
      if (!rst || !mon_en) begin
         prev_oe = 1'b0;
         oe_run  = 0;
         wv_run  = 0;
         in_gap  = 1'b0;
      end else begin
         if (gray_OE || lbp_WEN) chk("oe_wen_exclusive", {63'd0, gray_OE & lbp_WEN}, 64'd0);
         if (prev_oe || win_valid) chk("win_lags_oe", {63'd0, win_valid}, {63'd0, prev_oe});
         if (win_last && !win_valid) chk("win_last_without_valid", {63'd0, win_last}, 64'd0);

         if (gray_OE) begin
            oe_run++;
            if (ga_q.size() == 0) chk("gray_fetch_unexpected", 64'(ga_q.size()), 64'd1);
            else chk("gray_addr", {52'd0, gray_addr}, {52'd0, ga_q.pop_front()});
         end else if (oe_run != 0) begin
            chk("gray_oe_run", 64'(oe_run), 64'd9);
            oe_run = 0;
         end

         if (win_valid) begin
            win_t e;
            wv_run++;
            if (win_q.size() == 0) chk("win_unexpected", 64'(win_q.size()), 64'd1);
            else begin
               e = win_q.pop_front();
               chk("win_idx",  {60'd0, win_idx},  {60'd0, e.idx});
               chk("win_data", {56'd0, win_data}, {56'd0, e.data});
               chk("win_last", {63'd0, win_last}, {63'd0, e.last});
            end
         end else if (wv_run != 0) begin
            chk("win_valid_run", 64'(wv_run), 64'd9);
            wv_run = 0;
         end

         if (lbp_WEN) begin
            wr_t e;
            lbp_mem[lbp_addr] = lbp_data;
            if (wr_q.size() == 0) chk("lbp_write_unexpected", 64'(wr_q.size()), 64'd1);
            else begin
               e = wr_q.pop_front();
               chk("lbp_addr", {52'd0, lbp_addr}, {52'd0, e.addr});
               chk("lbp_data", {56'd0, lbp_data}, {56'd0, e.data});
            end
         end

         if (in_gap) begin
            if (lbp_WEN) begin
               chk("core_wait_cycles", 64'(gap), 64'(core_d + 1));
               in_gap = 1'b0;
            end else begin
               chk("wait_no_strobe", {62'd0, gray_OE, win_valid}, 64'd0);
               gap++;
            end
         end
         if (win_last) begin
            in_gap = 1'b1;
            gap    = 0;
         end
         prev_oe = gray_OE;
      end
   end

   initial begin
      int nb;
      int ni;
      for (int a = 0; a < NPIX; a++) begin
         gray_mem[a] = 8'((a * 37) ^ (a >> 4));
         lbp_mem[a]  = 8'hFF;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {14'd0, busy, finish, gray_OE, lbp_WEN, win_valid, win_last, gray_addr, lbp_addr, lbp_data, win_data, win_idx},
          64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", {63'd0, busy}, 64'd0);

      // Full frame, core answers 0xA5 one cycle after win_last; enable pulsed mid-frame
      core_d    = 0;
      core_resp = 8'hA5;
      for (int p = 0; p < NPIX; p++) push_pixel(p, 8'hA5);
      start_scan();
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      for (int i = 0; i < 60000 && !finish; i++) begin
         @(negedge clk);
         if (i == 1000) enable = 1'b1;
         if (i == 1001) enable = 1'b0;
      end
      chk("frame_finished", {63'd0, finish}, 64'd1);
      chk("frame_cycles", 64'(($time - t_start - PERIOD / 2) / PERIOD), 64'd50476);
      chk("busy_at_finish", {63'd0, busy}, 64'd0);
      chk("wr_q_left", 64'(wr_q.size()), 64'd0);
      chk("ga_q_left", 64'(ga_q.size()), 64'd0);
      chk("win_q_left", 64'(win_q.size()), 64'd0);
      nb = 0;
      ni = 0;
      for (int p = 0; p < NPIX; p++) begin
         if (is_border(p) && lbp_mem[p] == 8'h00) nb++;
         if (!is_border(p) && lbp_mem[p] == 8'hA5) ni++;
      end
      chk("border_zero_count", 64'(nb), 64'd252);
      chk("interior_a5_count", 64'(ni), 64'd3844);
      repeat (5) @(negedge clk);
      chk("finish_holds", {63'd0, finish}, 64'd1);
      chk("lbp_addr_holds", {52'd0, lbp_addr}, 64'd4095);

      // Restart from DONE: 20-cycle core stall, stray core_valid during the first FETCH
      core_d    = 20;
      core_resp = 8'h5A;
      spur_req  = 1'b1;
      for (int p = 0; p <= 130; p++) push_pixel(p, 8'h5A);
      start_scan();
      chk("restart_finish_clear", {63'd0, finish}, 64'd0);
      chk("restart_busy", {63'd0, busy}, 64'd1);
      for (int i = 0; i < 5000 && wr_q.size() != 1; i++) begin
         @(posedge clk);
         #1;
      end
      chk("reached_pixel_130", 64'(wr_q.size()), 64'd1);
      for (int i = 0; i < 20 && !gray_OE; i++) begin
         @(posedge clk);
         #1;
      end
      chk("fetch_130_started", {63'd0, gray_OE}, 64'd1);
      chk("fetch_130_center", {52'd0, gray_addr}, 64'd130);

      // Asynchronous abort in the middle of pixel 130's FETCH
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_outputs",
          {14'd0, busy, finish, gray_OE, lbp_WEN, win_valid, win_last, gray_addr, lbp_addr, lbp_data, win_data, win_idx},
          64'd0);
      ga_q.delete();
      win_q.delete();
      wr_q.delete();
      repeat (3) @(negedge clk);
      chk("abort_no_write", {63'd0, lbp_WEN}, 64'd0);
      rst = 1'b1;

      // Restart after reset rescans from pixel 0
      core_d    = 0;
      core_resp = 8'h77;
      for (int p = 0; p <= 66; p++) push_pixel(p, 8'h77);
      start_scan();
      chk("post_reset_busy", {63'd0, busy}, 64'd1);
      for (int i = 0; i < 1000 && wr_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      mon_en = 1'b0;
      chk("post_reset_writes_done", 64'(wr_q.size()), 64'd0);
      chk("post_reset_pixel65", {56'd0, lbp_mem[65]}, 64'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
